// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup for fetch, resolution/redirect and table update from EX.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_npc,
    input  logic              upd_valid,
    input  logic              upd_is_branch,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_npc,
    input  logic              flush_all,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [PERF_W-1:0] branch_cnt,
    output logic [PERF_W-1:0] mispredict_cnt
);

    localparam int INDEX_W = $clog2(ENTRIES);
    localparam int TAG_W   = XLEN - INDEX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX    = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [CTR_W-1:0]   ctr_d    [ENTRIES];

    logic [PERF_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [PERF_W-1:0]  mispredict_cnt_q, mispredict_cnt_d;

    logic [INDEX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0]   if_tag, upd_tag;
    logic               if_hit, uhit;
    logic               act_taken;
    logic [XLEN-1:0]    act_npc;

    always_comb begin
        if_idx     = if_pc[INDEX_W+1:2];
        if_tag     = if_pc[XLEN-1:INDEX_W+2];
        if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken = if_hit && ctr_q[if_idx][CTR_W-1];
        pred_npc   = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
    end

    always_comb begin
        upd_idx     = upd_pc[INDEX_W+1:2];
        upd_tag     = upd_pc[XLEN-1:INDEX_W+2];
        uhit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        act_taken   = upd_is_branch && upd_taken;
        act_npc     = act_taken ? upd_target : upd_pc + XLEN'(4);
        mispredict  = upd_valid && ((upd_pred_taken != act_taken) || (act_npc != upd_pred_npc));
        redirect_pc = upd_valid ? act_npc : '0;
    end

    // Table next state; flush and reset both suppress writes so no entry survives them.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_valid && !flush_all && !reset) begin
            if (upd_is_branch) begin
                if (uhit) begin
                    if (upd_taken) begin
                        if (ctr_q[upd_idx] != CTR_MAX) ctr_d[upd_idx] = ctr_q[upd_idx] + CTR_W'(1);
                        target_d[upd_idx] = upd_target;
                    end else if (ctr_q[upd_idx] != '0) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] - CTR_W'(1);
                    end
                end else if (upd_taken) begin
                    valid_d[upd_idx]  = 1'b1;
                    tag_d[upd_idx]    = upd_tag;
                    target_d[upd_idx] = upd_target;
                    ctr_d[upd_idx]    = CTR_WEAK_T;
                end
            end else if (uhit) begin
                valid_d[upd_idx] = 1'b0;
            end
        end
        if (flush_all) valid_d = '0;
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (upd_valid && upd_is_branch) branch_cnt_d = branch_cnt_q + PERF_W'(1);
        if (mispredict) mispredict_cnt_d = mispredict_cnt_q + PERF_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q          <= '0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            valid_q          <= valid_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule
